// File: rtl/uart_pkg.sv
// uart_pkg
//   Types and constants shared by the UART transmit and receive paths.
//   tx_state_t                 : transmitter frame state
//   UART_DATA_BITS             : data bits per frame (8N1)
//   UART_DEFAULT_CLKS_PER_BIT  : 21.55 MHz system clock / 115200 baud
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam int UART_DATA_BITS            = 8;
    localparam int UART_DEFAULT_CLKS_PER_BIT = 187;

endpackage

// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if
//   Bus-side view of the buffered UART transmitter.
//   tx_DI, tx_we, tx_ovf_clr          : master -> transmitter (byte, push strobe, overflow clear)
//   tx_full, tx_empty, tx_count       : queue status
//   tx_busy, tx_overflow              : frame in progress, sticky dropped-push flag
interface uart_tx_fifo_if #(
    parameter int FIFO_DEPTH = 16
);
    import uart_pkg::*;

    logic [UART_DATA_BITS-1:0]   tx_DI;
    logic                        tx_we;
    logic                        tx_ovf_clr;
    logic                        tx_full;
    logic                        tx_empty;
    logic [$clog2(FIFO_DEPTH):0] tx_count;
    logic                        tx_busy;
    logic                        tx_overflow;

    modport master (
        output tx_DI, tx_we, tx_ovf_clr,
        input  tx_full, tx_empty, tx_count, tx_busy, tx_overflow
    );

    modport slave (
        input  tx_DI, tx_we, tx_ovf_clr,
        output tx_full, tx_empty, tx_count, tx_busy, tx_overflow
    );
endinterface

// File: rtl/uart_fifo.sv
// uart_fifo
//   Synchronous FIFO, first-word fall-through: dout always shows the head entry,
//   so a pop consumes dout on the same edge.
//   clk, clear_n : clock, asynchronous active-low reset
//   push, din    : write strobe and data (ignored while full)
//   pop, dout    : read strobe (ignored while empty) and head data
//   full, empty, count : registered occupancy, valid after each edge
module uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic             clk,
    input  logic             clear_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0]    count_reg, count_next;
    logic             full_reg, empty_reg;
    logic             push_ok, pop_ok;

    assign push_ok = push && !full_reg;
    assign pop_ok  = pop && !empty_reg;

    always_comb begin
        count_next = count_reg;
        case ({push_ok, pop_ok})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    // Storage carries no reset; only pointers and flags define its contents.
    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr_reg] <= din;
    end

    // DEPTH is a power of two, so pointers wrap naturally.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            full_reg   <= 1'b0;
            empty_reg  <= 1'b1;
        end else begin
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            count_reg <= count_next;
            full_reg  <= (count_next == CW'(DEPTH));
            empty_reg <= (count_next == '0);
        end
    end

    assign dout  = mem[rd_ptr_reg];
    assign full  = full_reg;
    assign empty = empty_reg;
    assign count = count_reg;

endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
//   Buffered 8N1 transmitter: queued bytes are sent LSB first at CLKS_PER_BIT
//   clocks per bit, back-to-back with no idle gap, line idle high.
//   clk           : system clock
//   clear_n       : asynchronous active-low reset (aborts any frame, line high at once)
//   bus           : slave side of uart_tx_fifo_if (push, status, overflow)
//   uart_port_DO  : serial line, driven straight from a flop
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic           clk,
    input  logic           clear_n,
    uart_tx_fifo_if.slave  bus,
    output logic           uart_port_DO
);

    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    tx_state_t                 state_reg, state_next;
    logic [BW-1:0]             baud_reg, baud_next;
    logic [2:0]                bit_idx_reg, bit_idx_next;
    logic [UART_DATA_BITS-1:0] shift_reg, shift_next;
    logic                      line_reg, line_next;
    logic                      overflow_reg;
    logic                      baud_end;
    logic                      pop;
    logic                      fifo_full, fifo_empty;
    logic [UART_DATA_BITS-1:0] fifo_head;
    logic [CW-1:0]             fifo_count;

    uart_fifo #(
        .WIDTH (UART_DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .clear_n (clear_n),
        .push    (bus.tx_we),
        .din     (bus.tx_DI),
        .pop     (pop),
        .dout    (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign baud_end = (baud_reg == BW'(CLKS_PER_BIT - 1));

    // State register
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state_reg   <= IDLE;
            baud_reg    <= '0;
            bit_idx_reg <= '0;
            shift_reg   <= '0;
            line_reg    <= 1'b1;
        end else begin
            state_reg   <= state_next;
            baud_reg    <= baud_next;
            bit_idx_reg <= bit_idx_next;
            shift_reg   <= shift_next;
            line_reg    <= line_next;
        end
    end

    // Next-state logic. Pops rely on the registered empty flag, so a byte pushed
    // into an empty queue is only seen one edge later.
    always_comb begin
        state_next   = state_reg;
        baud_next    = baud_end ? '0 : baud_reg + 1'b1;
        bit_idx_next = bit_idx_reg;
        shift_next   = shift_reg;
        pop          = 1'b0;
        case (state_reg)
            IDLE: begin
                baud_next = '0;
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    shift_next = fifo_head;
                    state_next = START;
                end
            end
            START: begin
                if (baud_end) begin
                    state_next   = DATA;
                    bit_idx_next = '0;
                end
            end
            DATA: begin
                if (baud_end) begin
                    shift_next = shift_reg >> 1;
                    if (bit_idx_reg == 3'(UART_DATA_BITS - 1))
                        state_next = STOP;
                    else
                        bit_idx_next = bit_idx_reg + 1'b1;
                end
            end
            STOP: begin
                if (baud_end) begin
                    // Chain straight into the next start bit when more data waits.
                    if (!fifo_empty) begin
                        pop        = 1'b1;
                        shift_next = fifo_head;
                        state_next = START;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Output logic: the line level is computed from the upcoming state so the
    // flop presents it on the same edge the state changes.
    always_comb begin
        line_next = 1'b1;
        case (state_next)
            START:   line_next = 1'b0;
            DATA:    line_next = shift_next[0];
            default: line_next = 1'b1;
        endcase
        bus.tx_busy = (state_reg != IDLE);
    end

    // A dropped push takes priority over a clear in the same cycle.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n)
            overflow_reg <= 1'b0;
        else if (bus.tx_we && fifo_full)
            overflow_reg <= 1'b1;
        else if (bus.tx_ovf_clr)
            overflow_reg <= 1'b0;
    end

    assign bus.tx_full     = fifo_full;
    assign bus.tx_empty    = fifo_empty;
    assign bus.tx_count    = fifo_count;
    assign bus.tx_overflow = overflow_reg;
    assign uart_port_DO    = line_reg;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo
//   Drives the transmitter with directed and random pushes and compares every
//   cycle against a queue-and-frame-timer model of the transmitter.
module tb_uart_tx_fifo;
    import uart_pkg::*;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * CPB;

    logic clk = 1'b0;
    logic clear_n = 1'b1;
    logic serial_line;

    uart_tx_fifo_if #(.FIFO_DEPTH(DEPTH)) bus_if ();

    uart_tx_fifo #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk          (clk),
        .clear_n      (clear_n),
        .bus          (bus_if.slave),
        .uart_port_DO (serial_line)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: queued bytes, clocks left in the frame on the wire,
    // the byte on the wire and the sticky overflow flag.
    logic [7:0] mq[$];
    int         frame_left;
    logic [7:0] cur;
    logic       m_ovf;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic exp_line();
        int pos;
        if (frame_left == 0) return 1'b1;
        pos = (FRAME - frame_left) / CPB;
        if (pos == 0) return 1'b0;
        if (pos == 9) return 1'b1;
        return cur[pos-1];
    endfunction

    task automatic check_all();
        check("line",     {31'd0, serial_line},           {31'd0, exp_line()});
        check("busy",     {31'd0, bus_if.tx_busy},        {31'd0, frame_left > 0});
        check("count",    32'(bus_if.tx_count),           32'(mq.size()));
        check("full",     {31'd0, bus_if.tx_full},        {31'd0, mq.size() == DEPTH});
        check("empty",    {31'd0, bus_if.tx_empty},       {31'd0, mq.size() == 0});
        check("overflow", {31'd0, bus_if.tx_overflow},    {31'd0, m_ovf});
    endtask

    task automatic step(input logic we, input logic [7:0] d, input logic clr);
        int  pre;
        logic was_full;
        bus_if.tx_we      = we;
        bus_if.tx_DI      = d;
        bus_if.tx_ovf_clr = clr;
        @(posedge clk);
        pre      = mq.size();
        was_full = (pre == DEPTH);
        if (pre > 0 && frame_left <= 1) begin
            cur        = mq.pop_front();
            frame_left = FRAME;
        end else if (frame_left > 0) begin
            frame_left--;
        end
        if (we && was_full)
            m_ovf = 1'b1;
        else if (clr)
            m_ovf = 1'b0;
        if (we && !was_full)
            mq.push_back(d);
        #1;
        check_all();
    endtask

    // Asserts reset between edges and checks the line goes high before any edge.
    task automatic do_reset();
        #2;
        clear_n = 1'b0;
        #1;
        check("rst_line",     {31'd0, serial_line},        32'd1);
        check("rst_empty",    {31'd0, bus_if.tx_empty},    32'd1);
        check("rst_count",    32'(bus_if.tx_count),        32'd0);
        check("rst_busy",     {31'd0, bus_if.tx_busy},     32'd0);
        check("rst_overflow", {31'd0, bus_if.tx_overflow}, 32'd0);
        mq.delete();
        frame_left = 0;
        m_ovf      = 1'b0;
        @(posedge clk);
        #3;
        clear_n = 1'b1;
    endtask

    // Pushes one byte into an idle transmitter and samples each bit mid-period.
    task automatic send_sample(input logic [7:0] b, output logic [9:0] frm, output int busy_clks);
        int pos;
        frm       = '1;
        busy_clks = 0;
        step(1'b1, b, 1'b0);
        for (int i = 0; i < FRAME + 2; i++) begin
            step(1'b0, 8'h00, 1'b0);
            busy_clks += int'(bus_if.tx_busy);
            pos = i / CPB;
            if (i % CPB == CPB / 2 && pos < 10)
                frm[pos] = serial_line;
        end
    endtask

    initial begin
        logic [9:0] frm;
        int         busy_clks;
        int         guard;

        bus_if.tx_we      = 1'b0;
        bus_if.tx_DI      = 8'h00;
        bus_if.tx_ovf_clr = 1'b0;
        frame_left        = 0;
        m_ovf             = 1'b0;
        cur               = 8'h00;

        do_reset();
        step(1'b0, 8'h00, 1'b0);

        // Single byte
        send_sample(8'h41, frm, busy_clks);
        check("t2_frame", 32'(frm), 32'h282);
        check("t2_byte",  32'(frm[8:1]), 32'h41);
        check("t2_busy",  32'(busy_clks), 32'd40);

        // Two bytes back to back
        busy_clks = 0;
        step(1'b1, 8'h41, 1'b0);
        busy_clks += int'(bus_if.tx_busy);
        step(1'b1, 8'h42, 1'b0);
        busy_clks += int'(bus_if.tx_busy);
        for (int i = 0; i < 2 * FRAME + 5; i++) begin
            step(1'b0, 8'h00, 1'b0);
            busy_clks += int'(bus_if.tx_busy);
        end
        check("t3_busy", 32'(busy_clks), 32'd80);

        // Six pushes: one in flight, four queued, one dropped
        for (int i = 0; i < 6; i++)
            step(1'b1, 8'(8'h60 + i), 1'b0);
        check("t4_full",     {31'd0, bus_if.tx_full},     32'd1);
        check("t4_overflow", {31'd0, bus_if.tx_overflow}, 32'd1);
        step(1'b0, 8'h00, 1'b1);
        check("t4_ovf_clr",  {31'd0, bus_if.tx_overflow}, 32'd0);
        for (int i = 0; i < 5 * FRAME + 5; i++)
            step(1'b0, 8'h00, 1'b0);

        // Push while full on the same edge the stop bit ends
        for (int i = 0; i < 5; i++)
            step(1'b1, 8'(8'hA0 + i), 1'b0);
        guard = 0;
        while (frame_left != 1 && guard < 2 * FRAME) begin
            step(1'b0, 8'h00, 1'b0);
            guard++;
        end
        check("t5_align", 32'(frame_left), 32'd1);
        step(1'b1, 8'hEE, 1'b0);
        check("t5_count",    32'(bus_if.tx_count),        32'd3);
        check("t5_overflow", {31'd0, bus_if.tx_overflow}, 32'd1);
        for (int i = 0; i < 4 * FRAME + 5; i++)
            step(1'b0, 8'h00, 1'b0);

        // Reset in the middle of data bit 3, then a clean frame
        step(1'b1, 8'h5A, 1'b0);
        step(1'b1, 8'h33, 1'b0);
        for (int i = 0; i < 4 * CPB + 1; i++)
            step(1'b0, 8'h00, 1'b0);
        do_reset();
        step(1'b0, 8'h00, 1'b0);
        send_sample(8'h55, frm, busy_clks);
        check("t6_frame", 32'(frm), 32'h2AA);

        // Random traffic
        for (int i = 0; i < 1500; i++)
            step($urandom_range(0, 9) < 3, 8'($urandom), $urandom_range(0, 19) == 0);
        for (int i = 0; i < (DEPTH + 1) * FRAME + 5; i++)
            step(1'b0, 8'h00, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
